// File: rtl/perf_pkg.sv
// Shared types and index constants for the performance-monitor counter bank.
// Counter index 0 is the cycle counter; event strobe i lands in counter i+1.
package perf_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } perf_state_t;

    localparam int IDX_CYCLE = 0;

    localparam int EV_RETIRE = 0;
    localparam int EV_ICREQ  = 1;
    localparam int EV_ICHIT  = 2;
    localparam int EV_DCREQ  = 3;
    localparam int EV_DCHIT  = 4;
    localparam int EV_MEMRD  = 5;

    function automatic int evCounterIdx(input int ev);
        return ev + 1;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// One performance counter: increment enable, wrap or saturate at all-ones,
// sticky overflow flag and synchronous clear.
module perf_counter #(
    parameter int CNT_WIDTH = 32,
    parameter int SAT_MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 incEn,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf
);

    localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;

    logic atMax;

    assign atMax = (count == ALL_ONES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (incEn) begin
            if (atMax) begin
                // Saturating counters hold at all-ones; wrapping ones roll to 0.
                ovf <= 1'b1;
                if (SAT_MODE == 0) begin
                    count <= '0;
                end
            end else begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/perf_event_counter_bank.sv
// Performance-monitor bank: a cycle counter plus NUM_EVENTS event counters,
// frozen on halt and streamed out over a valid/ready dump port.
//
// state | meaning
// RUN   | counters live; halt moves to DUMP
// DUMP  | counters frozen; one word per handshake, dump_idx 0..NUM_EVENTS
// DONE  | dump finished; counters frozen and readable until clear
module perf_event_counter_bank
    import perf_pkg::*;
#(
    parameter  int NUM_EVENTS = 6,
    parameter  int CNT_WIDTH  = 32,
    parameter  int SAT_MODE   = 0,
    localparam int IDX_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  halt,
    input  logic                  clear,
    input  logic [IDX_W-1:0]      rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  rd_ovf,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [IDX_W-1:0]      dump_idx,
    output logic [CNT_WIDTH-1:0]  dump_data,
    output logic                  dump_ovf,
    output logic                  done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVENTS);

    perf_state_t            state;
    perf_state_t            stateNext;
    logic [IDX_W-1:0]       dumpIdx;
    logic [IDX_W-1:0]       dumpIdxNext;
    logic                   running;
    logic [NUM_EVENTS:0]    incEn;
    logic [NUM_EVENTS:0]    ovfVal;
    logic [CNT_WIDTH-1:0]   cntVal [NUM_EVENTS+1];

    assign running = (state == RUN);
    // Bit 0 is the always-on cycle strobe; event i feeds counter i+1.
    assign incEn   = {event_in, 1'b1} & {(NUM_EVENTS + 1){running}};

    for (genvar i = 0; i <= NUM_EVENTS; i++) begin : gCtr
        perf_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .SAT_MODE  (SAT_MODE)
        ) uCtr (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .incEn (incEn[i]),
            .count (cntVal[i]),
            .ovf   (ovfVal[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            dumpIdx <= '0;
        end else begin
            state   <= stateNext;
            dumpIdx <= dumpIdxNext;
        end
    end

    always_comb begin
        stateNext   = state;
        dumpIdxNext = dumpIdx;
        if (clear) begin
            stateNext   = RUN;
            dumpIdxNext = '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt) begin
                        stateNext   = DUMP;
                        dumpIdxNext = '0;
                    end
                end
                DUMP: begin
                    if (dump_ready) begin
                        if (dumpIdx == LAST_IDX) begin
                            stateNext = DONE;
                        end else begin
                            dumpIdxNext = dumpIdx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    stateNext = DONE;
                end
                default: begin
                    stateNext   = RUN;
                    dumpIdxNext = '0;
                end
            endcase
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_data   = '0;
        rd_ovf    = 1'b0;
        dump_data = '0;
        dump_ovf  = 1'b0;
        for (int i = 0; i <= NUM_EVENTS; i++) begin
            if (rd_sel == IDX_W'(i)) begin
                rd_data = cntVal[i];
                rd_ovf  = ovfVal[i];
            end
            if (dumpIdx == IDX_W'(i)) begin
                dump_data = cntVal[i];
                dump_ovf  = ovfVal[i];
            end
        end
    end

    assign dump_valid = (state == DUMP);
    assign done       = (state == DONE);
    assign dump_idx   = dumpIdx;

endmodule
